// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
//
// Purpose:
//   Sits between the Arty board pins / MMCM and the SoC. It does three jobs:
//   - brings the raw buttons and switches into the SoC clock domain with
//     two-flop synchronizers;
//   - debounces each input and emits one-cycle rise/fall pulses;
//   - generates the SoC's active-high reset. The reset is held until the MMCM
//     reports lock and a hold count has elapsed.
//
// Ports:
//   clk         in   SoC clock (MMCM output)
//   rst_n       in   asynchronous active-low reset (board ck_rst)
//   pll_locked  in   MMCM lock, asynchronous, synchronized internally
//   din         in   [NUM_IN] raw asynchronous inputs ({sw[3:0], btn[3:0]})
//   dout        out  [NUM_IN] debounced level
//   rise        out  [NUM_IN] one-cycle pulse on a debounced 0->1 change
//   fall        out  [NUM_IN] one-cycle pulse on a debounced 1->0 change
//   soc_rst     out  active-high SoC reset, asynchronous assert,
//                    synchronous deassert
//
// Optional feature (compile-time macro BOARD_INPUT_CONDITIONER_BTN_RST_EN):
//   When the macro is defined, a debounced press of button 0 (rise[0]) in HOLD
//   or RUN sends the reset FSM back to WAIT_LOCK. This soft-resets the SoC.
//   din[0] still appears on dout/rise/fall in both builds.
// -----------------------------------------------------------------------------
module board_input_conditioner #(
    parameter int NUM_IN          = 8,
    parameter int CLK_FREQ_MHZ    = 50,
    parameter int DEBOUNCE_US     = 10000,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic [NUM_IN-1:0] din,
    output logic [NUM_IN-1:0] dout,
    output logic [NUM_IN-1:0] rise,
    output logic [NUM_IN-1:0] fall,
    output logic              soc_rst
);

    localparam int DB_CYCLES = CLK_FREQ_MHZ * DEBOUNCE_US;
    localparam int CNT_W     = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the inputs and the MMCM lock
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] din_meta;
    logic [NUM_IN-1:0] s;
    logic              lk_meta;
    logic              lk;

    // NOTE: every flop is written with non-blocking assignments. Each stage
    // then samples the value its neighbour held before the edge, so the
    // two flops really form a two-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta <= '0;
            s        <= '0;
            lk_meta  <= 1'b0;
            lk       <= 1'b0;
        end else begin
            din_meta <= din;
            s        <= din_meta;
            lk_meta  <= pll_locked;
            lk       <= lk_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce. The counter measures how long the synchronized
    // input has disagreed with the debounced level. Any agreeing sample
    // restarts the count, so glitches shorter than DB_CYCLES are rejected.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_IN; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             up;
        logic             down;

        // NOTE: the counters are ordinary per-bit registers, not a memory.
        // Clearing them on reset discards an in-progress debounce, so no
        // stale pulse can fire after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                level <= 1'b0;
                up    <= 1'b0;
                down  <= 1'b0;
            end else begin
                up   <= 1'b0;
                down <= 1'b0;
                if (s[i] == level) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    level <= s[i];
                    cnt   <= '0;
                    up    <= s[i];
                    down  <= ~s[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign dout[i] = level;
        assign rise[i] = up;
        assign fall[i] = down;
    end

    // ------------------------------------------------------------------
    // Reset sequencer: WAIT_LOCK -> HOLD (RST_HOLD_CYCLES) -> RUN
    // ------------------------------------------------------------------
    logic              btn_kick;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] hcnt_nxt;

`ifdef BOARD_INPUT_CONDITIONER_BTN_RST_EN
    assign btn_kick = rise[0];
`else
    assign btn_kick = 1'b0;
`endif

    // NOTE: defaults first, so every path assigns both outputs and no latch
    // is inferred.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = HOLD;
                    hcnt_nxt  = '0;
                end
            end
            HOLD: begin
                if (!lk || btn_kick) begin
                    state_nxt = WAIT_LOCK;
                    hcnt_nxt  = '0;
                end else if (hcnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            RUN: begin
                if (!lk || btn_kick) begin
                    state_nxt = WAIT_LOCK;
                    hcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                hcnt_nxt  = '0;
            end
        endcase
    end

    // soc_rst is registered from the next state. It therefore changes on the
    // same edge as the state it describes, and it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_LOCK;
            hcnt    <= '0;
            soc_rst <= 1'b1;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            soc_rst <= (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_board_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_board_input_conditioner
//
// Purpose:
//   Self-checking bench for board_input_conditioner. It uses DB_CYCLES = 50 and
//   a reset hold of 16 cycles.
//   - Directed hand sequences and a vector table check exact cycle counts.
//   - A reference model runs on every negative edge for the whole run. It
//     works on sliding windows of past input history: an input bit flips once
//     all of the last 50 synchronized samples disagree with it, and soc_rst is
//     low once the synchronized lock has read high on the last 17 edges.
// -----------------------------------------------------------------------------
module tb_board_input_conditioner;

    localparam int NUM_IN   = 8;
    localparam int DB       = 50;
    localparam int HOLD_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pll_locked;
    logic [NUM_IN-1:0] din;
    logic [NUM_IN-1:0] dout;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] fall;
    logic              soc_rst;

    int n_cmp  = 0;
    int n_fail = 0;

    board_input_conditioner #(
        .NUM_IN         (NUM_IN),
        .CLK_FREQ_MHZ   (50),
        .DEBOUNCE_US    (1),
        .RST_HOLD_CYCLES(HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .din       (din),
        .dout      (dout),
        .rise      (rise),
        .fall      (fall),
        .soc_rst   (soc_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance n cycles; inputs are driven and directed checks are sampled 2ns
    // after each rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0] din_at_edge = '0;
    logic       pll_at_edge = 1'b0;
    logic       rst_at_edge = 1'b0;

    always @(posedge clk) begin
        din_at_edge <= din;
        pll_at_edge <= pll_locked;
        rst_at_edge <= rst_n;
    end

    logic [7:0] dq[$];    // dq[0] = din seen at the latest edge
    logic       pq[$];
    logic [7:0] dout_m, rise_m, fall_m;
    logic       soc_m;

    task automatic model_reset();
        dq.delete();
        pq.delete();
        repeat (DB + 2) dq.push_back(8'h00);
        repeat (HOLD_CYC + 3) pq.push_back(1'b0);
        dout_m = '0;
        rise_m = '0;
        fall_m = '0;
        soc_m  = 1'b1;
    endtask

    task automatic model_step();
        logic [7:0] w;
        logic       diff;
        if (!rst_n) begin
            model_reset();
        end else if (rst_at_edge) begin
            dq.push_front(din_at_edge);
            void'(dq.pop_back());
            pq.push_front(pll_at_edge);
            void'(pq.pop_back());
            rise_m = '0;
            fall_m = '0;
            // The debouncer acts on the input seen two edges earlier (two
            // sync flops), so the window covers entries 2 .. DB+1.
            for (int i = 0; i < NUM_IN; i++) begin
                diff = 1'b1;
                for (int j = 2; j < DB + 2; j++) begin
                    w = dq[j];
                    if (w[i] == dout_m[i]) diff = 1'b0;
                end
                if (diff) begin
                    dout_m[i] = ~dout_m[i];
                    if (dout_m[i]) rise_m[i] = 1'b1;
                    else           fall_m[i] = 1'b1;
                end
            end
            soc_m = 1'b0;
            for (int j = 2; j < HOLD_CYC + 3; j++)
                if (!pq[j]) soc_m = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            model_step();
            check("model_dout", dout, dout_m);
            check("model_rise", rise, rise_m);
            check("model_fall", fall, fall_m);
            check("model_soc_rst", {7'b0, soc_rst}, {7'b0, soc_m});
        end
    end

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] din;
        logic       pll;
        int         ncyc;
        logic [7:0] exp_dout;
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
        logic       exp_rst;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int pick;
        int len;

        // Clean press on bit 2
        vecs.push_back('{8'h04, 1'b1, 51, 8'h00, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h04, 1'b1, 1,  8'h04, 8'h04, 8'h00, 1'b0});
        vecs.push_back('{8'h04, 1'b1, 1,  8'h04, 8'h00, 8'h00, 1'b0});
        // Bit 1 bounces every 20 cycles for 200 cycles
        for (int k = 0; k < 10; k++)
            vecs.push_back('{(k % 2 == 0) ? 8'h06 : 8'h04, 1'b1, 20, 8'h04, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h06, 1'b1, 51, 8'h04, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h06, 1'b1, 1,  8'h06, 8'h02, 8'h00, 1'b0});
        vecs.push_back('{8'h06, 1'b1, 1,  8'h06, 8'h00, 8'h00, 1'b0});
        // Lock lost for 3 cycles while running
        vecs.push_back('{8'h06, 1'b0, 2,  8'h06, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h06, 1'b0, 1,  8'h06, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{8'h06, 1'b1, 18, 8'h06, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{8'h06, 1'b1, 1,  8'h06, 8'h00, 8'h00, 1'b0});
        // Button 0 press: no effect on soc_rst in the default build
        vecs.push_back('{8'h07, 1'b1, 51, 8'h06, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h07, 1'b1, 1,  8'h07, 8'h01, 8'h00, 1'b0});
        vecs.push_back('{8'h07, 1'b1, 30, 8'h07, 8'h00, 8'h00, 1'b0});
        // Release of bit 2 gives a fall pulse
        vecs.push_back('{8'h03, 1'b1, 51, 8'h07, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h03, 1'b1, 1,  8'h03, 8'h00, 8'h04, 1'b0});
        // 49 disagreeing samples, then one agreeing sample: no change
        vecs.push_back('{8'h02, 1'b1, 49, 8'h03, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h03, 1'b1, 10, 8'h03, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h02, 1'b1, 51, 8'h03, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{8'h02, 1'b1, 1,  8'h02, 8'h00, 8'h01, 1'b0});

        // Reset sequence
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        din        = '0;
        cyc(5);
        check("rst_dout", dout, 8'h00);
        check("rst_rise", rise, 8'h00);
        check("rst_fall", fall, 8'h00);
        check("rst_soc_rst", {7'b0, soc_rst}, 8'h01);
        rst_n = 1'b1;
        cyc(18);
        check("hold_soc_rst", {7'b0, soc_rst}, 8'h01);
        cyc(1);
        check("run_soc_rst", {7'b0, soc_rst}, 8'h00);

        // Vector table
        foreach (vecs[k]) begin
            din        = vecs[k].din;
            pll_locked = vecs[k].pll;
            cyc(vecs[k].ncyc);
            check($sformatf("vec%0d_dout", k), dout, vecs[k].exp_dout);
            check($sformatf("vec%0d_rise", k), rise, vecs[k].exp_rise);
            check($sformatf("vec%0d_fall", k), fall, vecs[k].exp_fall);
            check($sformatf("vec%0d_soc_rst", k), {7'b0, soc_rst}, {7'b0, vecs[k].exp_rst});
        end

        // Reset in the middle of a debounce
        din = 8'h22;
        cyc(30);
        check("middb_dout", dout, 8'h02);
        rst_n = 1'b0;
        #1;
        check("middb_rst_dout", dout, 8'h00);
        check("middb_rst_rise", rise, 8'h00);
        check("middb_rst_soc_rst", {7'b0, soc_rst}, 8'h01);
        cyc(3);
        rst_n = 1'b1;
        cyc(51);
        check("middb_pre_dout", dout, 8'h00);
        check("middb_pre_soc_rst", {7'b0, soc_rst}, 8'h00);
        cyc(1);
        check("middb_dout_up", dout, 8'h22);
        check("middb_rise", rise, 8'h22);
        cyc(1);
        check("middb_rise_end", rise, 8'h00);

        // Random stimulus; checked by the reference model on every cycle
        for (int seg = 0; seg < 70; seg++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 3)      len = int'($urandom_range(1, 6));
            else if (pick < 7) len = int'($urandom_range(45, 55));
            else               len = int'($urandom_range(56, 120));
            din        = din ^ 8'($urandom_range(1, 255));
            pll_locked = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(len);
        end
        pll_locked = 1'b1;
        cyc(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
